// File: rtl/ddr_axi_write_master.sv
// ddr_axi_write_master
//   AXI4 write master that drains the 256-bit DDR write FIFO into DDR.
//   A job (start address + byte length) is split into INCR bursts of at most
//   MAX_BURST_LEN beats that never cross a 4 KB boundary. Up to MAX_OUTSTANDING
//   bursts may await their B response. axi_idle reports that no job is active
//   and no responses are pending.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   ddr_conf                   job request, accepted on its rising edge while idle
//   ddr_st_addr, ddr_len       job start byte address / length in bytes
//   fifo_empty, fifo_rd_req,
//   fifo_data                  write FIFO (read data valid one cycle after pop)
//   m_axi_aw*, m_axi_w*,
//   m_axi_b*                   AXI4 write address / data / response channels
//   axi_idle                   no job active and no B responses outstanding
//   wr_err, wr_err_clr         sticky error on non-OKAY bresp (optional)
//
// Build option
//   DDR_WR_RESP_CHK_EN: adds wr_err / wr_err_clr; otherwise bresp is ignored.
module ddr_axi_write_master #(
  parameter int DDR_ADDR_LEN     = 32,
  parameter int SINGLE_LEN       = 24,
  parameter int C_AXI_DATA_WIDTH = 256,
  parameter int MAX_BURST_LEN    = 16,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ddr_conf,
  input  logic [DDR_ADDR_LEN-1:0]       ddr_st_addr,
  input  logic [SINGLE_LEN-1:0]         ddr_len,
  input  logic                          fifo_empty,
  output logic                          fifo_rd_req,
  input  logic [C_AXI_DATA_WIDTH-1:0]   fifo_data,
  output logic [DDR_ADDR_LEN-1:0]       m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic                          axi_idle
`ifdef DDR_WR_RESP_CHK_EN
  ,
  output logic                          wr_err,
  input  logic                          wr_err_clr
`endif
);

  localparam int BPB      = C_AXI_DATA_WIDTH / 8;
  localparam int SIZE_LOG = $clog2(BPB);
  localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  state_t                      state_reg, state_next;
  logic                        conf_reg;
  logic [DDR_ADDR_LEN-1:0]     addr_reg;
  logic [7:0]                  awlen_reg;
  logic [SINGLE_LEN-1:0]       rem_reg;      // beats left after the current burst
  logic [OUT_W-1:0]            out_reg;
  logic [8:0]                  req_cnt_reg;  // FIFO pops issued for this burst
  logic [8:0]                  sent_cnt_reg; // W beats accepted for this burst
  logic                        inflight_reg; // pop issued last cycle, data arrives now
  logic [1:0]                  skid_cnt_reg;
  logic                        skid_wr_reg, skid_rd_reg;
  logic [C_AXI_DATA_WIDTH-1:0] skid_mem [2];

  logic                        job_accept, aw_hs, w_hs, load_burst;
  logic [SINGLE_LEN:0]         len_round;
  logic [SINGLE_LEN-1:0]       total_beats, ld_rem;
  logic [DDR_ADDR_LEN-1:0]     ld_addr;
  logic [8:0]                  burst_cur, ld_burst;
  logic [2:0]                  skid_after_pop;

  // Largest legal burst from address a with rem beats left.
  function automatic logic [8:0] burst_beats(input logic [11:0] a,
                                             input logic [SINGLE_LEN-1:0] rem);
    logic [12:0] to_4k;
    logic [31:0] lim;
    to_4k = (13'd4096 - {1'b0, a}) >> SIZE_LOG;
    lim   = 32'(MAX_BURST_LEN);
    if (32'(to_4k) < lim) lim = 32'(to_4k);
    if (32'(rem) < lim)   lim = 32'(rem);
    return lim[8:0];
  endfunction

  assign job_accept  = (state_reg == IDLE) && ddr_conf && !conf_reg;
  assign len_round   = {1'b0, ddr_len} + (SINGLE_LEN+1)'(BPB - 1);
  assign total_beats = SINGLE_LEN'(len_round >> SIZE_LOG);
  assign aw_hs       = m_axi_awvalid && m_axi_awready;
  assign w_hs        = m_axi_wvalid && m_axi_wready;
  assign burst_cur   = {1'b0, awlen_reg} + 9'd1;

  always_comb begin
    state_next = state_reg;
    load_burst = 1'b0;
    ld_addr    = addr_reg;
    ld_rem     = rem_reg;
    case (state_reg)
      IDLE: if (job_accept) begin
        if (total_beats != '0) begin
          state_next = ADDR;
          load_burst = 1'b1;
          ld_addr    = ddr_st_addr & ~DDR_ADDR_LEN'(BPB - 1);
          ld_rem     = total_beats;
        end else begin
          // Zero-length job: one DRAIN cycle gives the single-cycle idle pulse.
          state_next = DRAIN;
        end
      end
      ADDR: if (aw_hs) state_next = DATA;
      DATA: if (w_hs && m_axi_wlast) begin
        if (rem_reg != '0) begin
          state_next = ADDR;
          load_burst = 1'b1;
          ld_addr    = addr_reg + (DDR_ADDR_LEN'(burst_cur) << SIZE_LOG);
        end else begin
          state_next = DRAIN;
        end
      end
      DRAIN: if (out_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ld_burst = burst_beats(ld_addr[11:0], ld_rem);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      conf_reg  <= 1'b0;
      addr_reg  <= '0;
      awlen_reg <= '0;
      rem_reg   <= '0;
    end else begin
      state_reg <= state_next;
      // Edge detector only samples while idle so a request seen while busy is dropped.
      conf_reg  <= (state_reg == IDLE) ? ddr_conf : 1'b1;
      if (load_burst) begin
        addr_reg  <= ld_addr;
        awlen_reg <= 8'(ld_burst - 9'd1);
        rem_reg   <= ld_rem - SINGLE_LEN'(ld_burst);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg <= '0;
    end else begin
      case ({aw_hs, m_axi_bvalid})
        2'b10:   out_reg <= out_reg + OUT_W'(1);
        2'b01:   out_reg <= out_reg - OUT_W'(1);
        default: out_reg <= out_reg;
      endcase
    end
  end

  // AW: fields come from registers loaded on entry to ADDR, so they are stable
  // while awvalid waits; outstanding can only fall during ADDR, so once raised
  // awvalid stays up until the handshake.
  assign m_axi_awvalid = (state_reg == ADDR) && (out_reg < OUT_W'(MAX_OUTSTANDING));
  assign m_axi_awaddr  = addr_reg;
  assign m_axi_awlen   = awlen_reg;
  assign m_axi_awsize  = 3'(SIZE_LOG);
  assign m_axi_awburst = 2'b01;
  assign m_axi_bready  = 1'b1;
  assign axi_idle      = (state_reg == IDLE) && (out_reg == '0);

  // Occupancy counts the entry leaving this cycle so a pop can be issued
  // every cycle while the master streams at full rate.
  assign skid_after_pop = {1'b0, skid_cnt_reg} + {2'b0, inflight_reg} - {2'b0, w_hs};
  assign fifo_rd_req    = (state_reg == DATA) && !fifo_empty &&
                          (skid_after_pop < 3'd2) && (req_cnt_reg < burst_cur);

  assign m_axi_wvalid = (skid_cnt_reg != 2'd0);
  assign m_axi_wdata  = skid_mem[skid_rd_reg];
  assign m_axi_wstrb  = '1;
  assign m_axi_wlast  = m_axi_wvalid && (sent_cnt_reg == {1'b0, awlen_reg});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt_reg  <= '0;
      sent_cnt_reg <= '0;
      inflight_reg <= 1'b0;
      skid_cnt_reg <= '0;
      skid_wr_reg  <= 1'b0;
      skid_rd_reg  <= 1'b0;
    end else begin
      inflight_reg <= fifo_rd_req;
      skid_cnt_reg <= skid_after_pop[1:0];
      if (inflight_reg) skid_wr_reg <= ~skid_wr_reg;
      if (w_hs)         skid_rd_reg <= ~skid_rd_reg;
      if (aw_hs) begin
        req_cnt_reg  <= '0;
        sent_cnt_reg <= '0;
      end else begin
        if (fifo_rd_req) req_cnt_reg  <= req_cnt_reg + 9'd1;
        if (w_hs)        sent_cnt_reg <= sent_cnt_reg + 9'd1;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_skid
    always_ff @(posedge clk) begin
      if (inflight_reg && (skid_wr_reg == 1'(gi))) skid_mem[gi] <= fifo_data;
    end
  end

`ifdef DDR_WR_RESP_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    wr_err <= 1'b0;
    else if (m_axi_bvalid && m_axi_bresp != 2'b00) wr_err <= 1'b1;
    else if (wr_err_clr)                           wr_err <= 1'b0;
  end
`else
  logic unused_bresp;
  assign unused_bresp = ^m_axi_bresp;
`endif

endmodule

// File: tb/tb_ddr_axi_write_master.sv
module tb_ddr_axi_write_master;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ddr_conf;
  logic [31:0]  ddr_st_addr;
  logic [23:0]  ddr_len;
  logic         fifo_empty;
  logic         fifo_rd_req;
  logic [255:0] fifo_data;
  logic [31:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic [1:0]   m_axi_awburst;
  logic         m_axi_awvalid, m_axi_awready;
  logic [255:0] m_axi_wdata;
  logic [31:0]  m_axi_wstrb;
  logic         m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]   m_axi_bresp;
  logic         m_axi_bvalid, m_axi_bready;
  logic         axi_idle;
`ifdef DDR_WR_RESP_CHK_EN
  logic         wr_err, wr_err_clr;
`endif

  always #5 clk = ~clk;

  ddr_axi_write_master dut (
    .clk(clk), .rst_n(rst_n), .ddr_conf(ddr_conf), .ddr_st_addr(ddr_st_addr),
    .ddr_len(ddr_len), .fifo_empty(fifo_empty), .fifo_rd_req(fifo_rd_req),
    .fifo_data(fifo_data), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .axi_idle(axi_idle)
`ifdef DDR_WR_RESP_CHK_EN
    , .wr_err(wr_err), .wr_err_clr(wr_err_clr)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard / environment state
  logic [255:0] fifo_q[$];
  logic [255:0] exp_w_q[$];
  logic [39:0]  exp_aw_q[$];
  logic [39:0]  aw_obs[$];
  int           aw_hist[$];
  int beat_w, wlast_cnt, b_sent, aw_total, b_total, aw_job, pops_job;
  int exp_total, exp_nb;
  bit pop_now, aw_stall, w_stall;
  logic [39:0]  aw_prev;
  logic [256:0] w_prev;
  bit aw_rand, w_rand, gap_en, b_hold, b_release;
  logic [1:0] bresp_val;

  // Input driver: everything changes 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      m_axi_bvalid = 1'b0;
      fifo_empty   = 1'b1;
    end else begin
      if (pop_now) begin
        if (fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
        pops_job++;
      end
      if (m_axi_bvalid) b_sent++;
      m_axi_bvalid = 1'b0;
      if (b_release) begin
        m_axi_bvalid = 1'b1;
        b_release = 1'b0;
      end else if (!b_hold && wlast_cnt > b_sent && $urandom_range(0, 1) == 1) begin
        m_axi_bvalid = 1'b1;
      end
      m_axi_bresp   = bresp_val;
      m_axi_awready = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      fifo_empty    = (fifo_q.size() == 0) || (gap_en && $urandom_range(0, 2) == 0);
    end
  end

  // Monitor: samples on the falling edge; a handshake seen here completes on
  // the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pop_now  = 1'b0;
      aw_stall = 1'b0;
      w_stall  = 1'b0;
    end else begin
      pop_now = fifo_rd_req && !fifo_empty;
      if (fifo_rd_req) check("pop_only_when_not_empty", fifo_empty, 1'b0);
      if (aw_stall) begin
        check("awvalid_held", m_axi_awvalid, 1'b1);
        check("aw_fields_stable", {m_axi_awaddr, m_axi_awlen}, aw_prev);
      end
      if (m_axi_awvalid && m_axi_awready) begin
        check("aw_below_max_outstanding", (aw_total - b_total) < 4, 1'b1);
        check("aw_expected", exp_aw_q.size() != 0, 1'b1);
        if (exp_aw_q.size() != 0)
          check("aw_addr_len", {m_axi_awaddr, m_axi_awlen}, exp_aw_q.pop_front());
        check("aw_size_burst", {m_axi_awsize, m_axi_awburst}, {3'd5, 2'b01});
        aw_obs.push_back({m_axi_awaddr, m_axi_awlen});
        aw_hist.push_back(int'(m_axi_awlen) + 1);
        aw_total++;
        aw_job++;
        $display("AW addr=%08h awlen=%0d", m_axi_awaddr, m_axi_awlen);
      end
      aw_stall = m_axi_awvalid && !m_axi_awready;
      aw_prev  = {m_axi_awaddr, m_axi_awlen};
      if (w_stall) begin
        check("wvalid_held", m_axi_wvalid, 1'b1);
        check("w_fields_stable", {m_axi_wlast, m_axi_wdata}, w_prev);
      end
      if (m_axi_wvalid && m_axi_wready) begin
        check("w_after_own_aw", aw_hist.size() != 0, 1'b1);
        if (aw_hist.size() != 0) begin
          beat_w++;
          check("wlast", m_axi_wlast, beat_w == aw_hist[0]);
          if (beat_w == aw_hist[0]) begin
            void'(aw_hist.pop_front());
            beat_w = 0;
            wlast_cnt++;
          end
        end
        check("w_expected", exp_w_q.size() != 0, 1'b1);
        if (exp_w_q.size() != 0) check("wdata_order", m_axi_wdata, exp_w_q.pop_front());
        check("wstrb", m_axi_wstrb, 32'hFFFF_FFFF);
      end
      w_stall = m_axi_wvalid && !m_axi_wready;
      w_prev  = {m_axi_wlast, m_axi_wdata};
      if (m_axi_bvalid) b_total++;
    end
  end

  // Reference model: bursts from plain arithmetic on the job parameters.
  task automatic prep_job(input logic [31:0] addr, input int len);
    longint a, rem, b, room;
    exp_aw_q.delete(); exp_w_q.delete(); fifo_q.delete(); aw_obs.delete();
    exp_total = (len + 31) / 32;
    exp_nb = 0;
    a = longint'(addr) / 32 * 32;
    rem = exp_total;
    while (rem > 0) begin
      room = (4096 - (a % 4096)) / 32;
      b = rem;
      if (b > 16) b = 16;
      if (b > room) b = room;
      exp_aw_q.push_back({32'(a), 8'(b - 1)});
      a += b * 32;
      rem -= b;
      exp_nb++;
    end
    for (int i = 0; i < exp_total; i++) begin
      logic [255:0] d;
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      fifo_q.push_back(d);
      exp_w_q.push_back(d);
    end
    aw_job = 0;
    pops_job = 0;
    ddr_st_addr = addr;
    ddr_len = 24'(len);
  endtask

  task automatic start_job();
    @(posedge clk); #1 ddr_conf = 1'b1;
    @(negedge clk);
    check("idle_before_accept", axi_idle, 1'b1);
    @(posedge clk); #1 ddr_conf = 1'b0;
    @(negedge clk);
    check("idle_drop_after_accept", axi_idle, 1'b0);
  endtask

  task automatic finish_job(input string name, input bit zero_len);
    int lows, waited;
    lows = 1;
    waited = 0;
    while (!axi_idle && waited < 5000) begin
      @(negedge clk);
      waited++;
      if (!axi_idle) lows++;
    end
    check("job_done_in_time", waited < 5000, 1'b1);
    if (zero_len) check("len0_idle_low_cycles", lows, 1);
    check("aw_count", aw_job, exp_nb);
    check("aw_all_issued", exp_aw_q.size(), 0);
    check("w_all_sent", exp_w_q.size(), 0);
    check("fifo_pops", pops_job, exp_total);
    $display("JOB %s addr=%08h len=%0d beats=%0d bursts=%0d busy_cycles=%0d",
             name, ddr_st_addr, ddr_len, exp_total, aw_job, lows);
  endtask

  task automatic run_job(input string name, input logic [31:0] addr, input int len);
    prep_job(addr, len);
    start_job();
    finish_job(name, len == 0);
  endtask

  task automatic flush_env();
    fifo_q.delete(); exp_w_q.delete(); exp_aw_q.delete(); aw_hist.delete();
    beat_w = 0; wlast_cnt = 0; b_sent = 0; aw_total = 0; b_total = 0;
    ddr_conf = 1'b0;
    m_axi_bvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ddr_conf = 1'b0; ddr_st_addr = '0; ddr_len = '0;
    fifo_empty = 1'b1; fifo_data = '0; m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
    aw_rand = 0; w_rand = 0; gap_en = 0; b_hold = 0; b_release = 0; bresp_val = 2'b00;
`ifdef DDR_WR_RESP_CHK_EN
    wr_err_clr = 1'b0;
`endif
    flush_env();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awvalid", m_axi_awvalid, 1'b0);
    check("rst_wvalid", m_axi_wvalid, 1'b0);
    check("rst_wlast", m_axi_wlast, 1'b0);
    check("rst_fifo_rd_req", fifo_rd_req, 1'b0);
    check("rst_awaddr_awlen", {m_axi_awaddr, m_axi_awlen}, 40'd0);
    check("rst_axi_idle", axi_idle, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single 16-beat burst; a second request while busy must be ignored.
    prep_job(32'h0000_1000, 512);
    start_job();
    repeat (3) @(posedge clk);
    #1 ddr_conf = 1'b1;
    @(posedge clk); #1 ddr_conf = 1'b0;
    finish_job("t1_single_burst", 1'b0);
    check("t1_aw", aw_obs[0], {32'h0000_1000, 8'd15});
    repeat (5) @(negedge clk);
    check("t1_busy_conf_ignored", axi_idle, 1'b1);

    // 4 KB boundary split.
    run_job("t2_4k_split", 32'h0000_0FC0, 1024);
    check("t2_nbursts", aw_obs.size(), 3);
    check("t2_aw0", aw_obs[0], {32'h0000_0FC0, 8'd1});
    check("t2_aw1", aw_obs[1], {32'h0000_1000, 8'd15});
    check("t2_aw2", aw_obs[2], {32'h0000_1200, 8'd13});

    // Partial beat rounding and zero length.
    run_job("t3_len40", 32'h0000_2000, 40);
    check("t3_aw", aw_obs[0], {32'h0000_2000, 8'd1});
    run_job("t3_len0", 32'h0000_3000, 0);

    // Outstanding limit: B withheld.
    begin
      int n;
      b_hold = 1;
      prep_job(32'h0001_0000, 4096);
      start_job();
      n = 0;
      while (aw_job < 4 && n < 2000) begin @(negedge clk); n++; end
      repeat (30) @(negedge clk);
      check("t4_aw_capped", aw_job, 4);
      check("t4_aw_blocked", m_axi_awvalid, 1'b0);
      b_release = 1;
      @(negedge clk);
      check("t4_aw_waits_for_b", m_axi_awvalid, 1'b0);
      @(negedge clk);
      check("t4_aw_after_b", m_axi_awvalid, 1'b1);
      b_hold = 0;
      finish_job("t4_outstanding", 1'b0);
    end

    // Random jobs with FIFO gaps and random ready.
    aw_rand = 1; w_rand = 1; gap_en = 1;
    for (int j = 0; j < 8; j++) begin
      int len;
      len = (j == 3) ? 0 : int'($urandom_range(1, 3000));
      run_job("t5_random", 32'($urandom_range(0, 32'h0FFF_FFFF)), len);
    end

    // Reset in the middle of a data phase, then a clean job.
    begin
      int n;
      prep_job(32'h0002_0F00, 2048);
      start_job();
      n = 0;
      while (!m_axi_wvalid && n < 500) begin @(negedge clk); n++; end
      check("t6_reached_data", m_axi_wvalid, 1'b1);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      check("t6_rst_awvalid", m_axi_awvalid, 1'b0);
      check("t6_rst_wvalid", m_axi_wvalid, 1'b0);
      check("t6_rst_wlast", m_axi_wlast, 1'b0);
      check("t6_rst_fifo_rd_req", fifo_rd_req, 1'b0);
      check("t6_rst_awaddr_awlen", {m_axi_awaddr, m_axi_awlen}, 40'd0);
      check("t6_rst_axi_idle", axi_idle, 1'b1);
      flush_env();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      run_job("t6_after_reset", 32'h0000_5040, 700);
    end

`ifdef DDR_WR_RESP_CHK_EN
    aw_rand = 0; w_rand = 0; gap_en = 0;
    @(negedge clk);
    check("t7_err_clear_start", wr_err, 1'b0);
    bresp_val = 2'b10;
    run_job("t7_slverr", 32'h0000_6000, 64);
    bresp_val = 2'b00;
    repeat (3) @(negedge clk);
    check("t7_err_sticky", wr_err, 1'b1);
    @(posedge clk); #1 wr_err_clr = 1'b1;
    @(posedge clk); #1 wr_err_clr = 1'b0;
    @(negedge clk);
    check("t7_err_cleared", wr_err, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
